// File: rtl/deserializer.sv
// ----------------------------------------------------------------------------
// deserializer
//
// Serial-to-parallel converter, receive-side twin of the serializer.
// It collects an MSB-first bit stream into DATA_BUS_WIDTH-bit words. A word
// is emitted in either of two cases:
//   - when the last bit of the word arrives (full word, mod = 0), or
//   - when the qualifier drops mid-word (partial word, mod = bit count).
// Partial words are left-aligned and their unused low bits are zero.
//
// Ports:
//   clk_i            in   1               clock, rising edge
//   arst_i           in   1               asynchronous active-high reset
//   ser_data_i       in   1               serial data bit, MSB first
//   ser_data_val_i   in   1               ser_data_i valid this cycle
//   deser_data_o     out  DATA_BUS_WIDTH  reassembled word (held between pulses)
//   deser_data_mod_o out  DATA_MOD_WIDTH  valid bit count, 0 = full word
//   deser_data_val_o out  1               one-cycle word-valid pulse
// ----------------------------------------------------------------------------
module deserializer #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int DATA_MOD_WIDTH = 4
) (
   input  logic                      clk_i,
   input  logic                      arst_i,
   input  logic                      ser_data_i,
   input  logic                      ser_data_val_i,
   output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
   output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
   output logic                      deser_data_val_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RECV = 1'b1;

   // Counter value while the final bit of a word is being sampled.
   localparam logic [DATA_MOD_WIDTH-1:0] LAST_BIT = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);

   localparam logic [DATA_BUS_WIDTH-1:0] WORD_ZERO = {DATA_BUS_WIDTH{1'b0}};
   localparam logic [DATA_MOD_WIDTH-1:0] MOD_ZERO  = {DATA_MOD_WIDTH{1'b0}};
   localparam logic [DATA_MOD_WIDTH-1:0] MOD_ONE   = DATA_MOD_WIDTH'(1);

   // Returns a word with only the bit at position (MSB - idx) set to b.
   // Bit number idx of a burst therefore lands idx places below the MSB.
   function automatic logic [DATA_BUS_WIDTH-1:0] place_bit(
      input logic                      b,
      input logic [DATA_MOD_WIDTH-1:0] idx
   );
      logic [DATA_BUS_WIDTH-1:0] one_hot;
      one_hot = {{(DATA_BUS_WIDTH-1){1'b0}}, b};
      return one_hot << (LAST_BIT - idx);
   endfunction

   logic [0:0]                state_r;
   logic [DATA_MOD_WIDTH-1:0] cnt_r;
   logic [DATA_BUS_WIDTH-1:0] shift_r;
   logic [DATA_BUS_WIDTH-1:0] data_r;
   logic [DATA_MOD_WIDTH-1:0] mod_r;
   logic                      val_r;

   logic [0:0]                state_s;
   logic [DATA_MOD_WIDTH-1:0] cnt_s;
   logic [DATA_BUS_WIDTH-1:0] shift_s;
   logic [DATA_BUS_WIDTH-1:0] data_s;
   logic [DATA_MOD_WIDTH-1:0] mod_s;
   logic                      val_s;
   logic [DATA_BUS_WIDTH-1:0] merged_s;

   // Next-state computation for the burst framing FSM and its datapath.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      shift_s  = shift_r;
      data_s   = data_r;
      mod_s    = mod_r;
      val_s    = 1'b0;
      // Shift register with the current bit merged in at the counter slot.
      merged_s = shift_r | place_bit(ser_data_i, cnt_r);

      case (state_r)
         IDLE: begin
            if (ser_data_val_i) begin
               // shift_r is always zero here, so merged_s holds just bit MSB.
               shift_s = merged_s;
               cnt_s   = MOD_ONE;
               state_s = RECV;
            end else begin
               state_s = IDLE;
            end
         end

         RECV: begin
            if (ser_data_val_i) begin
               if (cnt_r == LAST_BIT) begin
                  // Last bit completes the word; the next valid bit starts
                  // a fresh word from IDLE with no gap needed.
                  data_s  = merged_s;
                  mod_s   = MOD_ZERO;
                  val_s   = 1'b1;
                  shift_s = WORD_ZERO;
                  cnt_s   = MOD_ZERO;
                  state_s = IDLE;
               end else begin
                  shift_s = merged_s;
                  cnt_s   = cnt_r + MOD_ONE;
               end
            end else begin
               // Qualifier gap ends a short burst: emit what we have.
               data_s  = shift_r;
               mod_s   = cnt_r;
               val_s   = 1'b1;
               shift_s = WORD_ZERO;
               cnt_s   = MOD_ZERO;
               state_s = IDLE;
            end
         end

         default: begin
            state_s = IDLE;
            cnt_s   = MOD_ZERO;
            shift_s = WORD_ZERO;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously on reset.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_r <= IDLE;
         cnt_r   <= MOD_ZERO;
         shift_r <= WORD_ZERO;
         data_r  <= WORD_ZERO;
         mod_r   <= MOD_ZERO;
         val_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         shift_r <= shift_s;
         data_r  <= data_s;
         mod_r   <= mod_s;
         val_r   <= val_s;
      end
   end

   assign deser_data_o     = data_r;
   assign deser_data_mod_o = mod_r;
   assign deser_data_val_o = val_r;

endmodule

// File: tb/tb_deserializer.sv
// ----------------------------------------------------------------------------
// tb_deserializer
//
// Directed self-checking bench for deserializer. Bits are driven on the
// falling edge; a monitor logs every output pulse (with its cycle number)
// on the falling edge, and each scenario checks the log against hand-computed
// words, bit counts and latencies.
// ----------------------------------------------------------------------------
module tb_deserializer;

   logic        clk;
   logic        arst_i;
   logic        ser_data_i;
   logic        ser_data_val_i;
   logic [15:0] deser_data_o;
   logic [3:0]  deser_data_mod_o;
   logic        deser_data_val_o;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic [3:0]  mod;
   } pulse_t;

   pulse_t pulses[$];
   int     cyc       = 0;
   int     last_cyc  = 0;
   int     first_cyc = 0;
   int     n_checks  = 0;
   int     n_fail    = 0;

   deserializer #(
      .DATA_BUS_WIDTH(16),
      .DATA_MOD_WIDTH(4)
   ) dut (
      .clk_i            (clk),
      .arst_i           (arst_i),
      .ser_data_i       (ser_data_i),
      .ser_data_val_i   (ser_data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_mod_o (deser_data_mod_o),
      .deser_data_val_o (deser_data_val_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter, stepped on each active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every output pulse away from the active edge.
   always @(negedge clk) begin
      if (deser_data_val_o === 1'b1)
         pulses.push_back('{cyc: cyc, data: deser_data_o, mod: deser_data_mod_o});
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive the top nbits of w, MSB first, one bit per cycle.
   task automatic send_word(input logic [15:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ser_data_i     = w[15-i];
         ser_data_val_i = 1'b1;
         last_cyc       = cyc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ser_data_i     = 1'b0;
         ser_data_val_i = 1'b0;
      end
   endtask

   // Check a single logged pulse against word, count and latency.
   task automatic check_one(input string tag, input logic [15:0] w, input logic [3:0] m,
                            input int lat);
      check_eq({tag, "_count"}, pulses.size(), 1);
      if (pulses.size() > 0) begin
         check_eq({tag, "_data"}, pulses[0].data, w);
         check_eq({tag, "_mod"}, pulses[0].mod, m);
         check_eq({tag, "_lat"}, pulses[0].cyc - last_cyc, lat);
      end
      pulses.delete();
   endtask

   initial begin
      arst_i         = 1'b1;
      ser_data_i     = 1'b0;
      ser_data_val_i = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_eq("rst_data", deser_data_o, 16'h0000);
      check_eq("rst_mod", deser_data_mod_o, 4'h0);
      check_eq("rst_val", deser_data_val_o, 1'b0);
      arst_i = 1'b0;
      idle(5);
      check_eq("rst_idle_pulses", pulses.size(), 0);
      pulses.delete();

      // Full word: pulse one cycle after bit 16, outputs hold afterwards.
      send_word(16'hA5C3, 16);
      idle(4);
      check_one("full", 16'hA5C3, 4'd0, 1);
      check_eq("full_hold_data", deser_data_o, 16'hA5C3);
      check_eq("full_hold_val", deser_data_val_o, 1'b0);

      // Partial word 1,0,1,1,0: pulse two cycles after last bit.
      send_word(16'hB000, 5);
      idle(4);
      check_one("part5", 16'hB000, 4'd5, 2);

      // Back-to-back full words, 32 contiguous bits.
      send_word(16'h1234, 16);
      first_cyc = last_cyc;
      send_word(16'hFFFF, 16);
      idle(4);
      check_eq("b2b_count", pulses.size(), 2);
      if (pulses.size() == 2) begin
         check_eq("b2b_data0", pulses[0].data, 16'h1234);
         check_eq("b2b_mod0", pulses[0].mod, 4'd0);
         check_eq("b2b_lat0", pulses[0].cyc - first_cyc, 1);
         check_eq("b2b_data1", pulses[1].data, 16'hFFFF);
         check_eq("b2b_mod1", pulses[1].mod, 4'd0);
         check_eq("b2b_gap", pulses[1].cyc - pulses[0].cyc, 16);
      end
      pulses.delete();

      // Single-bit burst.
      send_word(16'h8000, 1);
      idle(4);
      check_one("bit1", 16'h8000, 4'd1, 2);

      // Fifteen ones.
      send_word(16'hFFFE, 15);
      idle(4);
      check_one("bit15", 16'hFFFE, 4'd15, 2);

      // Two short bursts with no gap merge: 3 bits 101 then 2 bits 11.
      send_word(16'hA000, 3);
      send_word(16'hC000, 2);
      idle(4);
      check_one("merge", 16'hB800, 4'd5, 2);

      // Seven bits, then reset asserted between edges.
      send_word(16'hFFFF, 7);
      #2;
      arst_i = 1'b1;
      #1;
      check_eq("arst_data", deser_data_o, 16'h0000);
      check_eq("arst_mod", deser_data_mod_o, 4'h0);
      check_eq("arst_val", deser_data_val_o, 1'b0);
      @(negedge clk);
      ser_data_val_i = 1'b0;
      arst_i         = 1'b0;
      idle(4);
      check_eq("arst_no_pulse", pulses.size(), 0);
      pulses.delete();

      // Recovery after reset.
      send_word(16'h00FF, 16);
      idle(4);
      check_one("recover", 16'h00FF, 4'd0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
